// File: rtl/spi_txn_sched.sv
// spi_txn_sched: round-robin scheduler that shares one SPI master among NREQ clients.
// Each grant issues a single start pulse, waits for completion or timeout, then holds a quiet gap.
module spi_txn_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255,
  parameter int GAP     = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_rx,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            err,
  output logic            busy,
  output logic            spi_tx_en,
  output logic            spi_rx_en,
  output logic            mode_select,
  input  logic            spi_done
);

  localparam int              IW       = $clog2(NREQ);
  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]   T_TERM   = TW'(TIMEOUT);
  localparam logic [7:0]      GAP_TERM = 8'(GAP);
  localparam logic [NREQ-1:0] ONE      = NREQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [TW-1:0]   tcnt, tcnt_n;
  logic [7:0]      gcnt, gcnt_n;
  logic [NREQ-1:0] gnt_n, done_n;
  logic            err_n, busy_n, tx_n, rx_n, mode_n;

  logic            found;
  logic [IW-1:0]   pick;

  // First requester strictly after the last granted one, wrapping around.
  always_comb begin : arb
    logic [IW-1:0] cand;
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    tcnt_n  = tcnt;
    gcnt_n  = gcnt;
    gnt_n   = gnt;
    done_n  = '0;
    err_n   = 1'b0;
    busy_n  = busy;
    tx_n    = 1'b0;
    rx_n    = 1'b0;
    mode_n  = mode_select;
    case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (found) begin
          ptr_n   = pick;
          mode_n  = req_rx[pick];
          gnt_n   = ONE << pick;
          busy_n  = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        rx_n    = mode_select;
        tx_n    = !mode_select;
        tcnt_n  = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the timeout cycle counts as success.
        if (spi_done) begin
          done_n  = gnt;
          gnt_n   = '0;
          gcnt_n  = '0;
          state_n = S_GAP;
        end else if (tcnt == T_LAST) begin
          done_n  = gnt;
          err_n   = 1'b1;
          gnt_n   = '0;
          tcnt_n  = T_TERM;
          gcnt_n  = '0;
          state_n = S_GAP;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      S_GAP: begin
        if (gcnt == GAP_TERM) begin
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else begin
          gcnt_n = gcnt + 8'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= IW'(NREQ - 1);
      tcnt        <= '0;
      gcnt        <= '0;
      gnt         <= '0;
      done        <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      spi_tx_en   <= 1'b0;
      spi_rx_en   <= 1'b0;
      mode_select <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      tcnt        <= tcnt_n;
      gcnt        <= gcnt_n;
      gnt         <= gnt_n;
      done        <= done_n;
      err         <= err_n;
      busy        <= busy_n;
      spi_tx_en   <= tx_n;
      spi_rx_en   <= rx_n;
      mode_select <= mode_n;
    end
  end

endmodule

// File: tb/tb_spi_txn_sched.sv
// tb_spi_txn_sched: directed bench with a scoreboard of expected start pulses and completions.
module tb_spi_txn_sched;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 255;
  localparam int GAP     = 20;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req, req_rx, gnt, done;
  logic            err, busy, spi_tx_en, spi_rx_en, mode_select, spi_done;

  typedef struct packed { logic [NREQ-1:0] gnt; logic rx; } start_t;
  typedef struct packed { logic [NREQ-1:0] done; logic err; } done_t;

  start_t exp_start[$];
  done_t  exp_done[$];
  start_t es;
  done_t  ed;
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_txn_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rx(req_rx), .gnt(gnt), .done(done),
    .err(err), .busy(busy), .spi_tx_en(spi_tx_en), .spi_rx_en(spi_rx_en),
    .mode_select(mode_select), .spi_done(spi_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] rx);
    req    = r;
    req_rx = rx;
  endtask

  task automatic waitStart(output int at);
    int n;
    n = 0;
    while (!(spi_tx_en || spi_rx_en) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("start_seen", 32'(spi_tx_en | spi_rx_en), 32'(1));
    at = cyc;
  endtask

  // Called on the negedge where the start pulse is visible; spi_done is sampled d edges later.
  task automatic pulseDone(input int d);
    repeat (d - 1) @(negedge clk);
    spi_done = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_reached", 32'(busy), 32'(0));
  endtask

  // Every start pulse and completion pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (spi_tx_en || spi_rx_en) begin
      checkOutput("start_both", 32'(spi_tx_en & spi_rx_en), 32'(0));
      if (exp_start.size() == 0) begin
        checkOutput("start_unexpected", 32'(exp_start.size()), 32'(1));
      end else begin
        es = exp_start.pop_front();
        checkOutput("start_gnt", 32'(gnt), 32'(es.gnt));
        checkOutput("start_rx", 32'(spi_rx_en), 32'(es.rx));
        checkOutput("start_mode", 32'(mode_select), 32'(es.rx));
      end
    end
    if (done != '0 || err) begin
      if (exp_done.size() == 0) begin
        checkOutput("done_unexpected", 32'(exp_done.size()), 32'(1));
      end else begin
        ed = exp_done.pop_front();
        checkOutput("done_vec", 32'(done), 32'(ed.done));
        checkOutput("done_err", 32'(err), 32'(ed.err));
        checkOutput("done_gnt_low", 32'(gnt), 32'(0));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [NREQ-1:0] order [5];
    logic [NREQ-1:0] rxv;
    int t, prev, cnt;

    rst = 1'b1;
    spi_done = 1'b0;
    applyStimulus('0, '0);
    repeat (3) @(negedge clk);
    checkOutput("rst_gnt", 32'(gnt), 32'(0));
    checkOutput("rst_done", 32'(done), 32'(0));
    checkOutput("rst_err", 32'(err), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_tx", 32'(spi_tx_en), 32'(0));
    checkOutput("rst_rx", 32'(spi_rx_en), 32'(0));
    checkOutput("rst_mode", 32'(mode_select), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single write to requester 0");
    applyStimulus(4'b0001, 4'b0000);
    exp_start.push_back('{gnt: 4'b0001, rx: 1'b0});
    @(negedge clk);
    checkOutput("t1_gnt", 32'(gnt), 32'(4'b0001));
    checkOutput("t1_busy", 32'(busy), 32'(1));
    checkOutput("t1_no_early_start", 32'(spi_tx_en), 32'(0));
    applyStimulus('0, '0);
    waitStart(t);
    exp_done.push_back('{done: 4'b0001, err: 1'b0});
    pulseDone(10);
    // busy stays up through GAP+1 gap cycles after the done cycle
    cnt = 0;
    while (busy && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("t1_busy_fall", cnt, GAP + 1);

    $display("[TB] round robin with all requesters active");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rxv = 4'b1010;
    applyStimulus(4'b1111, rxv);
    for (int i = 0; i < 5; i++) begin
      exp_start.push_back('{gnt: order[i], rx: |(order[i] & rxv)});
    end
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      waitStart(t);
      if (i > 0) checkOutput("t2_spacing", t - prev, 4 + GAP + 3);
      prev = t;
      exp_done.push_back('{done: order[i], err: 1'b0});
      pulseDone(4);
      if (i == 4) applyStimulus('0, '0);
    end
    waitIdle();

    $display("[TB] read from requester 2 with no completion");
    applyStimulus(4'b0100, 4'b0100);
    exp_start.push_back('{gnt: 4'b0100, rx: 1'b1});
    exp_done.push_back('{done: 4'b0100, err: 1'b1});
    @(negedge clk);
    applyStimulus('0, '0);
    waitStart(t);
    cnt = 0;
    while (done == '0 && cnt < 300) begin
      @(negedge clk);
      cnt++;
      if (cnt == 100) checkOutput("t3_mode_wait", 32'(mode_select), 32'(1));
    end
    checkOutput("t3_timeout_len", cnt, TIMEOUT);
    checkOutput("t3_err", 32'(err), 32'(1));
    waitIdle();
    checkOutput("t3_mode_hold_idle", 32'(mode_select), 32'(1));

    $display("[TB] completion on the timeout cycle");
    applyStimulus(4'b0001, 4'b0000);
    exp_start.push_back('{gnt: 4'b0001, rx: 1'b0});
    exp_done.push_back('{done: 4'b0001, err: 1'b0});
    waitStart(t);
    applyStimulus('0, '0);
    pulseDone(TIMEOUT);
    checkOutput("t4_done", 32'(done), 32'(4'b0001));
    checkOutput("t4_err", 32'(err), 32'(0));
    waitIdle();

    $display("[TB] reset during wait");
    applyStimulus(4'b1000, 4'b0000);
    exp_start.push_back('{gnt: 4'b1000, rx: 1'b0});
    waitStart(t);
    applyStimulus('0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_gnt", 32'(gnt), 32'(0));
    checkOutput("t5_done", 32'(done), 32'(0));
    checkOutput("t5_busy", 32'(busy), 32'(0));
    checkOutput("t5_err", 32'(err), 32'(0));
    rst = 1'b0;
    spi_done = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
    checkOutput("t5_idle_spi_done", 32'(busy), 32'(0));

    $display("[TB] request dropped after grant, stray completion in gap");
    applyStimulus(4'b1010, 4'b0000);
    exp_start.push_back('{gnt: 4'b0010, rx: 1'b0});
    @(negedge clk);
    checkOutput("t5_first_gnt", 32'(gnt), 32'(4'b0010));
    applyStimulus('0, '0);
    waitStart(t);
    exp_done.push_back('{done: 4'b0010, err: 1'b0});
    pulseDone(5);
    repeat (3) @(negedge clk);
    spi_done = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
    checkOutput("t6_stray_done", 32'(done), 32'(0));
    checkOutput("t6_gap_busy", 32'(busy), 32'(1));
    waitIdle();
    repeat (5) @(negedge clk);

    checkOutput("sb_start_empty", 32'(exp_start.size()), 32'(0));
    checkOutput("sb_done_empty", 32'(exp_done.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
